// File: rtl/uart_rom_loader_pkg.sv
// Shared constants for the UART ROM boot-loader: frame FSM encoding, receiver
// state encoding, sync byte and bit-period derivation.
package uart_rom_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [2:0] ST_SYNC   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHK    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, glitch rejection
// on the start bit, one-cycle byte_valid / frame_err pulses.
module uart_rx_byte
  import uart_rom_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int                CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta, rx_sync, rx_prev;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rx_meta    <= uart_rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A line back high at mid-start was a glitch, not a start bit.
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_rom_loader.sv
// UART boot-loader: parses A5/LEN/data[/CHK] frames, writes 32-bit words into
// the instruction ROM and releases core reset. Option: UART_ROM_LOADER_CHECKSUM_EN.
module uart_rom_loader
  import uart_rom_loader_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int ADDR_W       = 12,
  parameter int TIMEOUT_CLKS = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);
  localparam int          CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [31:0] MAX_WORDS    = 32'd1 << ADDR_W;
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CLKS - 1);

  logic        byte_valid, frame_err;
  logic [7:0]  byte_data;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  logic [2:0]        state;
  logic [7:0]        len_lo;
  logic [15:0]       word_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_buf;
  logic [31:0]       idle_cnt;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  logic [15:0] len_rx;
  logic        len_bad, frame_active, timed_out, last_word;

  assign len_rx       = {byte_data, len_lo};
  assign len_bad      = (len_rx == 16'd0) || (32'(len_rx) > MAX_WORDS);
  assign frame_active = state inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK};
  assign timed_out    = frame_active && !byte_valid && (idle_cnt == TIMEOUT_LAST);
  assign last_word    = (32'(word_idx) + 32'd1 == 32'(word_cnt));

  always_ff @(posedge clk) begin
    if (!rst) begin
      rom_we     <= 1'b0;
      rom_waddr  <= '0;
      rom_wdata  <= '0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      state      <= ST_SYNC;
      len_lo     <= '0;
      word_cnt   <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      idle_cnt   <= '0;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      rom_we <= 1'b0;
      if (!frame_active || byte_valid) idle_cnt <= '0;
      else                             idle_cnt <= idle_cnt + 32'd1;

      if (frame_active && (frame_err || timed_out)) begin
        state    <= ST_ERR;
        load_err <= 1'b1;
      end else begin
        case (state)
          ST_SYNC:
            if (byte_valid && byte_data == SYNC_BYTE) state <= ST_LEN_LO;
          ST_LEN_LO:
            if (byte_valid) begin
              len_lo <= byte_data;
              state  <= ST_LEN_HI;
            end
          ST_LEN_HI:
            if (byte_valid) begin
              word_cnt <= len_rx;
              word_idx <= '0;
              byte_cnt <= '0;
              if (len_bad) begin
                state    <= ST_ERR;
                load_err <= 1'b1;
              end else begin
                state <= ST_DATA;
              end
            end
          ST_DATA:
            if (rom_we) begin
              word_idx <= word_idx + 1'b1;
              if (last_word) begin
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                state <= ST_CHK;
`else
                state      <= ST_DONE;
                load_done  <= 1'b1;
                core_rst_n <= 1'b1;
`endif
              end
            end else if (byte_valid) begin
              // Little-endian: first byte ends up in [7:0] after four shifts.
              word_buf <= {byte_data, word_buf[23:8]};
              byte_cnt <= byte_cnt + 2'd1;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
              checksum <= checksum + byte_data;
`endif
              if (byte_cnt == 2'd3) begin
                rom_we    <= 1'b1;
                rom_waddr <= word_idx;
                rom_wdata <= {byte_data, word_buf};
              end
            end
`ifdef UART_ROM_LOADER_CHECKSUM_EN
          ST_CHK:
            if (byte_valid) begin
              if (byte_data == checksum) begin
                state      <= ST_DONE;
                load_done  <= 1'b1;
                core_rst_n <= 1'b1;
              end else begin
                state    <= ST_ERR;
                load_err <= 1'b1;
              end
            end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rom_loader.sv
// Self-checking bench for uart_rom_loader at 10 clocks per bit; expected writes
// and outcome come from a frame-level model (honours UART_ROM_LOADER_CHECKSUM_EN).
module tb_uart_rom_loader;
  localparam int ADDR_W   = 12;
  localparam int BIT_CLKS = 10;
  localparam int TIMEOUT  = 500;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              uart_rx = 1'b1;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0]       rom_wdata;
  logic              core_rst_n, load_done, load_err;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];
`ifdef UART_ROM_LOADER_CHECKSUM_EN
  int chk_delta = 0;
`endif

  always #5 clk = ~clk;

  uart_rom_loader #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .ADDR_W(ADDR_W), .TIMEOUT_CLKS(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .rom_we(rom_we), .rom_waddr(rom_waddr),
    .rom_wdata(rom_wdata), .core_rst_n(core_rst_n), .load_done(load_done), .load_err(load_err)
  );

  always @(negedge clk)
    if (rom_we === 1'b1) begin
      got_addr.push_back(rom_waddr);
      got_data.push_back(rom_wdata);
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    uart_rx = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (BIT_CLKS) @(negedge clk);
    uart_rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] n, input logic [7:0] data[$]);
    send_byte(8'hA5, 1'b1);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
    foreach (data[i]) send_byte(data[i], 1'b1);
`ifdef UART_ROM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] sum = 8'h00;
      foreach (data[i]) sum = sum + data[i];
      send_byte(sum + 8'(chk_delta), 1'b1);
    end
`endif
  endtask

  // Frame-level reference: which words land where, and whether the load succeeds.
  task automatic model(input int n, input logic [7:0] data[$], output bit ok,
                       output logic [31:0] words[$]);
    words = {};
    ok = (n >= 1) && (n <= (1 << ADDR_W));
    if (ok)
      for (int w = 0; w < n; w++)
        words.push_back(32'(data[4*w]) + (32'(data[4*w+1]) << 8) +
                        (32'(data[4*w+2]) << 16) + (32'(data[4*w+3]) << 24));
`ifdef UART_ROM_LOADER_CHECKSUM_EN
    if (chk_delta % 256 != 0) ok = 1'b0;
`endif
  endtask

  task automatic wait_end(input string tag);
    int cyc = 0;
    while (!(load_done || load_err) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".finished"}, 32'(load_done | load_err), 1);
  endtask

  task automatic check_writes(input string tag, input logic [31:0] words[$]);
    check({tag, ".we_count"}, got_data.size(), words.size());
    foreach (words[i])
      if (i < got_data.size()) begin
        check($sformatf("%s.addr%0d", tag, i), 32'(got_addr[i]), i);
        check($sformatf("%s.data%0d", tag, i), got_data[i], words[i]);
      end
  endtask

  task automatic run_frame(input string tag, input int n, input logic [7:0] data[$]);
    bit ok;
    logic [31:0] words[$];
    model(n, data, ok, words);
    send_frame(16'(n), data);
    wait_end(tag);
    repeat (5) @(negedge clk);
    check({tag, ".done"}, 32'(load_done), 32'(ok));
    check({tag, ".err"}, 32'(load_err), 32'(!ok));
    check({tag, ".core_rst_n"}, 32'(core_rst_n), 32'(ok));
    check_writes(tag, words);
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] b;
    int cyc;
    int n;

    // Reset state, sampled while rst is held low
    repeat (3) @(negedge clk);
    check("rst.rom_we", 32'(rom_we), 0);
    check("rst.rom_waddr", 32'(rom_waddr), 0);
    check("rst.rom_wdata", rom_wdata, 0);
    check("rst.core_rst_n", 32'(core_rst_n), 0);
    check("rst.load_done", 32'(load_done), 0);
    check("rst.load_err", 32'(load_err), 0);
    rst = 1'b1;

    // Leading garbage then the two-word reference image
    send_byte(8'h00, 1'b1);
    send_byte(8'h37, 1'b1);
    d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_frame("basic", 2, d);
    send_byte(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    check("done.ignores_bytes", 32'(got_data.size()), 2);

`ifdef UART_ROM_LOADER_CHECKSUM_EN
    do_reset();
    chk_delta = 1;
    run_frame("bad_chk", 2, d);
    chk_delta = 0;
`endif

    // Illegal lengths
    do_reset();
    d = {};
    run_frame("len_zero", 0, d);
    do_reset();
    run_frame("len_big", 32'h1001, d);

    // Timeout after two data bytes of a one-word frame
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    cyc = 0;
    while (!load_err && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout.err", 32'(load_err), 1);
    check("timeout.window", 32'(cyc >= 460 && cyc <= 520), 1);
    check("timeout.core_rst_n", 32'(core_rst_n), 0);
    check("timeout.we_count", got_data.size(), 0);

    // Start-bit glitch and a framing error while hunting for sync are silent
    do_reset();
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch.err", 32'(load_err), 0);
    send_byte(8'hA5, 1'b0);
    repeat (20) @(negedge clk);
    check("sync_ferr.err", 32'(load_err), 0);
    d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame("after_glitch", 1, d);

    // Stop bit forced low inside DATA
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b0);
    wait_end("data_ferr");
    check("data_ferr.err", 32'(load_err), 1);
    check("data_ferr.done", 32'(load_done), 0);

    // One-cycle reset mid-DATA, then a fresh one-word frame
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h99, 1'b1);
    send_byte(8'h88, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    got_addr.delete();
    got_data.delete();
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame("mid_rst", 1, d);

    // Randomised frames with random non-sync lead-in bytes
    for (int t = 0; t < 4; t++) begin
      do_reset();
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, 1'b1);
      end
      n = $urandom_range(1, 5);
      d = {};
      for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      chk_delta = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0;
`endif
      run_frame($sformatf("rand%0d", t), n, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
